// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the SPI flash responder.
// Holds the frame state encoding, accepted opcodes and the byte-lane helper.
package spi_flash_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        DATA,
        IGNORE
    } state_t;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;
    localparam int         DUMMY_CYCLES  = 8;

    // Byte 0 of a word lives in bits [7:0], so the flash byte order is little-endian.
    function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
        logic [7:0] result;
        case (idx)
            2'd0:    result = word[7:0];
            2'd1:    result = word[15:8];
            2'd2:    result = word[23:16];
            default: result = word[31:24];
        endcase
        return result;
    endfunction

endpackage

// File: rtl/spi_flash_mem.sv
// Flash image storage: MEM_WORDS x 32 synchronous RAM, one write port and one registered read port.
// A same-cycle write and read of one word returns the old contents; the array itself is never reset.
module spi_flash_mem #(
    parameter int MEM_WORDS = 4096,
    parameter int AW        = $clog2(MEM_WORDS)
) (
    input  logic          clock,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [MEM_WORDS];

    // rd_data holds its value between reads so the frame logic can pick later bytes of the same word.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/spi_flash_responder.sv
// SPI mode-0 NOR-flash responder answering READ (0x03) frames from an internal RAM image.
// Define SPI_FLASH_FAST_READ_EN to also accept FAST_READ (0x0B) followed by 8 dummy clocks.
module spi_flash_responder #(
    parameter int         MEM_WORDS = 4096,
    parameter logic [7:0] CMD_READ  = 8'h03,
    parameter int         ADDR_W    = 24
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         spi_sck,
    input  logic                         spi_ss_n,
    input  logic                         spi_mosi,
    output logic                         spi_miso,
    input  logic                         bd_we,
    input  logic [$clog2(MEM_WORDS)-1:0] bd_addr,
    input  logic [31:0]                  bd_wdata,
    output logic                         busy,
    output logic                         cmd_err
);

    import spi_flash_pkg::*;

    localparam int MEM_AW = $clog2(MEM_WORDS);
    localparam int PTR_W  = MEM_AW + 2;
    localparam int CNT_W  = $clog2(ADDR_W);

    localparam logic [CNT_W-1:0] BYTE_LAST    = CNT_W'(7);
    localparam logic [CNT_W-1:0] ADDR_LAST    = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] PREFETCH_BIT = CNT_W'(3);
`ifdef SPI_FLASH_FAST_READ_EN
    localparam logic [CNT_W-1:0] DUMMY_LAST   = CNT_W'(DUMMY_CYCLES - 1);
`endif

    state_t            state;
    state_t            next_state;
    logic [2:0]        sck_sync;
    logic [2:0]        ss_sync;
    logic [1:0]        mosi_sync;
    logic              sck_rise;
    logic              sck_fall;
    logic              ss_rise;
    logic              ss_fall;
    logic              mosi_s;
    logic [CNT_W-1:0]  bit_cnt;
    logic [PTR_W-2:0]  in_shift;
    logic [7:0]        opcode_next;
    logic [PTR_W-1:0]  addr_next;
    logic              opcode_ok;
    logic [7:0]        out_shift;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_inc;
    logic              load_pending;
    logic              rd_en;
    logic [MEM_AW-1:0] rd_word;
    logic [31:0]       rd_data;
`ifdef SPI_FLASH_FAST_READ_EN
    logic              fast_mode;
`endif

    // All three pins share the same synchronizer depth, so sck edges and mosi stay aligned.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sck_sync  <= 3'b000;
            ss_sync   <= 3'b111;
            mosi_sync <= 2'b00;
        end else begin
            sck_sync  <= {sck_sync[1:0], spi_sck};
            ss_sync   <= {ss_sync[1:0], spi_ss_n};
            mosi_sync <= {mosi_sync[0], spi_mosi};
        end
    end

    assign sck_rise = sck_sync[1] & ~sck_sync[2];
    assign sck_fall = ~sck_sync[1] & sck_sync[2];
    assign ss_rise  = ss_sync[1] & ~ss_sync[2];
    assign ss_fall  = ~ss_sync[1] & ss_sync[2];
    assign mosi_s   = mosi_sync[1];

    // Only the low PTR_W address bits are kept, which is what makes the address wrap modulo the image size.
    assign opcode_next = {in_shift[6:0], mosi_s};
    assign addr_next   = {in_shift, mosi_s};
    assign ptr_inc     = ptr + PTR_W'(1);

    always_comb begin
        opcode_ok = (opcode_next == CMD_READ);
`ifdef SPI_FLASH_FAST_READ_EN
        if (opcode_next == CMD_FAST_READ) begin
            opcode_ok = 1'b1;
        end
`endif
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The read port is driven from here so a read can launch in the same cycle as the decision to stream.
    always_comb begin
        next_state = state;
        rd_en      = 1'b0;
        rd_word    = ptr[PTR_W-1:2];
        if (ss_rise) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (ss_fall) begin
                        next_state = CMD;
                    end
                end
                CMD: begin
                    if (sck_rise && bit_cnt == BYTE_LAST) begin
                        next_state = opcode_ok ? ADDR : IGNORE;
                    end
                end
                ADDR: begin
                    if (sck_rise && bit_cnt == ADDR_LAST) begin
`ifdef SPI_FLASH_FAST_READ_EN
                        if (fast_mode) begin
                            next_state = DUMMY;
                        end else begin
                            next_state = DATA;
                            rd_en      = 1'b1;
                            rd_word    = addr_next[PTR_W-1:2];
                        end
`else
                        next_state = DATA;
                        rd_en      = 1'b1;
                        rd_word    = addr_next[PTR_W-1:2];
`endif
                    end
                end
`ifdef SPI_FLASH_FAST_READ_EN
                DUMMY: begin
                    if (sck_rise && bit_cnt == DUMMY_LAST) begin
                        next_state = DATA;
                        rd_en      = 1'b1;
                    end
                end
`endif
                DATA: begin
                    if (sck_fall && bit_cnt == PREFETCH_BIT && ptr[1:0] == 2'd3) begin
                        rd_en   = 1'b1;
                        rd_word = ptr[PTR_W-1:2] + MEM_AW'(1);
                    end
                end
                IGNORE: begin
                    next_state = IGNORE;
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            spi_miso     <= 1'b0;
            busy         <= 1'b0;
            cmd_err      <= 1'b0;
            bit_cnt      <= '0;
            in_shift     <= '0;
            out_shift    <= '0;
            ptr          <= '0;
            load_pending <= 1'b0;
`ifdef SPI_FLASH_FAST_READ_EN
            fast_mode    <= 1'b0;
`endif
        end else begin
            cmd_err <= 1'b0;
            if (ss_rise) begin
                spi_miso     <= 1'b0;
                busy         <= 1'b0;
                bit_cnt      <= '0;
                in_shift     <= '0;
                out_shift    <= '0;
                load_pending <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (ss_fall) begin
                            busy     <= 1'b1;
                            bit_cnt  <= '0;
                            spi_miso <= 1'b0;
                        end
                    end
                    CMD: begin
                        if (sck_rise) begin
                            in_shift <= addr_next[PTR_W-2:0];
                            if (bit_cnt == BYTE_LAST) begin
                                bit_cnt <= '0;
                                cmd_err <= ~opcode_ok;
`ifdef SPI_FLASH_FAST_READ_EN
                                fast_mode <= (opcode_next == CMD_FAST_READ);
`endif
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    ADDR: begin
                        if (sck_rise) begin
                            in_shift <= addr_next[PTR_W-2:0];
                            if (bit_cnt == ADDR_LAST) begin
                                bit_cnt <= '0;
                                ptr     <= addr_next;
`ifdef SPI_FLASH_FAST_READ_EN
                                load_pending <= ~fast_mode;
`else
                                load_pending <= 1'b1;
`endif
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
`ifdef SPI_FLASH_FAST_READ_EN
                    DUMMY: begin
                        if (sck_rise) begin
                            if (bit_cnt == DUMMY_LAST) begin
                                bit_cnt      <= '0;
                                load_pending <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
`endif
                    // The first byte lands one clock after the read; sck low lasts at least two clocks.
                    DATA: begin
                        if (load_pending) begin
                            out_shift    <= byte_sel(rd_data, ptr[1:0]);
                            load_pending <= 1'b0;
                        end else if (sck_fall) begin
                            spi_miso <= out_shift[7];
                            if (bit_cnt == BYTE_LAST) begin
                                bit_cnt   <= '0;
                                ptr       <= ptr_inc;
                                out_shift <= byte_sel(rd_data, ptr_inc[1:0]);
                            end else begin
                                bit_cnt   <= bit_cnt + CNT_W'(1);
                                out_shift <= {out_shift[6:0], 1'b0};
                            end
                        end
                    end
                    IGNORE: begin
                        spi_miso <= 1'b0;
                    end
                    default: begin
                        spi_miso <= 1'b0;
                    end
                endcase
            end
        end
    end

    spi_flash_mem #(
        .MEM_WORDS(MEM_WORDS)
    ) u_mem (
        .clock   (clock),
        .wr_en   (bd_we),
        .wr_addr (bd_addr),
        .wr_data (bd_wdata),
        .rd_en   (rd_en),
        .rd_addr (rd_word),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_spi_flash_responder.sv
// Self-checking bench for spi_flash_responder: an SPI mode-0 master model plus a byte scoreboard.
// Honours SPI_FLASH_FAST_READ_EN to pick the expected handling of opcode 0x0B.
module tb_spi_flash_responder;

    localparam int MEM_WORDS = 4096;
    localparam int HALF      = 4;
`ifdef SPI_FLASH_FAST_READ_EN
    localparam bit FAST_EN = 1'b1;
`else
    localparam bit FAST_EN = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        spi_sck;
    logic        spi_ss_n;
    logic        spi_mosi;
    logic        spi_miso;
    logic        bd_we;
    logic [11:0] bd_addr;
    logic [31:0] bd_wdata;
    logic        busy;
    logic        cmd_err;

    int          n_compared   = 0;
    int          n_mismatched = 0;
    int          cmd_err_cnt  = 0;
    logic [31:0] model [MEM_WORDS];
    logic [7:0]  exp_q [$];
    logic [71:0] last_rx;

    spi_flash_responder #(
        .MEM_WORDS(MEM_WORDS),
        .CMD_READ (8'h03),
        .ADDR_W   (24)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .spi_sck  (spi_sck),
        .spi_ss_n (spi_ss_n),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .bd_we    (bd_we),
        .bd_addr  (bd_addr),
        .bd_wdata (bd_wdata),
        .busy     (busy),
        .cmd_err  (cmd_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (cmd_err) cmd_err_cnt <= cmd_err_cnt + 1;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] modelByte(input int p);
        logic [31:0] w;
        w = model[(p >> 2) % MEM_WORDS];
        return w[8*(p % 4) +: 8];
    endfunction

    task automatic bdWrite(input int word, input logic [31:0] data);
        bd_we    = 1'b1;
        bd_addr  = 12'(word);
        bd_wdata = data;
        @(negedge clock);
        bd_we    = 1'b0;
        model[word] = data;
    endtask

    task automatic spiBits(input logic [71:0] tx, input int nbits, output logic [71:0] rx);
        rx = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            spi_mosi = tx[i];
            repeat (HALF) @(negedge clock);
            rx = {rx[70:0], spi_miso};
            spi_sck = 1'b1;
            repeat (HALF) @(negedge clock);
            spi_sck = 1'b0;
        end
        spi_mosi = 1'b0;
    endtask

    task automatic runFrame(input logic [71:0] tx, input int nbits, output logic [71:0] rx,
                            output int busy_lat);
        spi_ss_n = 1'b0;
        repeat (HALF) @(negedge clock);
        spiBits(tx, nbits, rx);
        repeat (HALF) @(negedge clock);
        checkOutput("busy_in_frame", 32'(busy), 32'd1);
        spi_ss_n = 1'b1;
        busy_lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clock);
            if (!busy) begin
                busy_lat = k;
                break;
            end
        end
        repeat (HALF) @(negedge clock);
    endtask

    task automatic applyStimulus(input string tag, input logic [7:0] op, input logic [23:0] addr,
                                 input bit fast);
        logic [71:0] tx;
        int          nb;
        int          lat;
        int          err0;
        bit          is_read;
        nb      = fast ? 72 : 64;
        tx      = fast ? {op, addr, 8'h00, 32'h0} : {8'h00, op, addr, 32'h0};
        is_read = (op == 8'h03) || (FAST_EN && op == 8'h0B);
        if (is_read) begin
            for (int i = 0; i < 4; i++) exp_q.push_back(modelByte((int'(addr) + i) & 16'h3FFF));
        end
        err0 = cmd_err_cnt;
        runFrame(tx, nb, last_rx, lat);
        last_rx = last_rx & ((72'd1 << nb) - 72'd1);
        checkOutput({tag, "_busy_lat"}, 32'(lat), 32'd3);
        checkOutput({tag, "_miso_after"}, 32'(spi_miso), 32'd0);
        checkOutput({tag, "_prefix_zero"}, 32'(last_rx >> 32), 32'd0);
        checkOutput({tag, "_cmd_err"}, 32'(cmd_err_cnt - err0), is_read ? 32'd0 : 32'd1);
    endtask

    task automatic drainScoreboard(input string tag);
        for (int k = 0; k < 4; k++) begin
            if (exp_q.size() == 0) begin
                checkOutput({tag, "_sb_empty"}, 32'd0, 32'd1);
            end else begin
                checkOutput($sformatf("%s_byte%0d", tag, k), 32'(last_rx[31-8*k -: 8]),
                            32'(exp_q.pop_front()));
            end
        end
    endtask

    initial begin
        int          lat;
        logic [71:0] rx;
        logic [7:0]  b;
        reset = 1'b1;
        spi_sck = 1'b0;
        spi_ss_n = 1'b1;
        spi_mosi = 1'b0;
        bd_we = 1'b0;
        bd_addr = '0;
        bd_wdata = '0;
        for (int i = 0; i < MEM_WORDS; i++) model[i] = 32'h0;
        repeat (3) @(negedge clock);
        checkOutput("reset_miso", 32'(spi_miso), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_cmd_err", 32'(cmd_err), 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clock);

        bdWrite(0, 32'h04030201);
        applyStimulus("t1", 8'h03, 24'h000000, 1'b0);
        checkOutput("t1_rx", last_rx[31:0], 32'h01020304);
        drainScoreboard("t1");

        bdWrite(0, 32'h44332211);
        bdWrite(1, 32'h88776655);
        applyStimulus("t2", 8'h03, 24'h000002, 1'b0);
        drainScoreboard("t2");

        bdWrite(MEM_WORDS - 1, 32'hAA000000);
        applyStimulus("t3", 8'h03, 24'h003FFF, 1'b0);
        checkOutput("t3_rx", last_rx[31:16], 32'h0000AA11);
        drainScoreboard("t3");

        applyStimulus("t4", 8'h9F, 24'h000000, 1'b0);
        checkOutput("t4_ignore_rx", last_rx[31:0], 32'h0);
        applyStimulus("t4b", 8'h03, 24'h000004, 1'b0);
        drainScoreboard("t4b");

        runFrame({52'h0, 8'h03, 12'h000}, 20, rx, lat);
        checkOutput("t5_abort_busy_lat", 32'(lat), 32'd3);
        checkOutput("t5_abort_miso", 32'(spi_miso), 32'd0);
        applyStimulus("t5b", 8'h03, 24'h000001, 1'b0);
        drainScoreboard("t5b");

        b = modelByte(16'h3FFF);
        spi_ss_n = 1'b0;
        repeat (HALF) @(negedge clock);
        spiBits({40'h0, 8'h03, 24'h003FFF}, 32, rx);
        repeat (HALF) @(negedge clock);
        checkOutput("t6_miso_pre_reset", 32'(spi_miso), 32'(b[7]));
        reset = 1'b1;
        #1;
        checkOutput("t6_miso_in_reset", 32'(spi_miso), 32'd0);
        checkOutput("t6_busy_in_reset", 32'(busy), 32'd0);
        @(negedge clock);
        spi_ss_n = 1'b1;
        repeat (HALF) @(negedge clock);
        reset = 1'b0;
        repeat (HALF) @(negedge clock);
        applyStimulus("t6b", 8'h03, 24'h003FFF, 1'b0);
        drainScoreboard("t6b");

        applyStimulus("t7", 8'h0B, 24'h000000, FAST_EN);
        if (FAST_EN) begin
            drainScoreboard("t7");
        end else begin
            checkOutput("t7_ignore_rx", last_rx[31:0], 32'h0);
        end
        checkOutput("sb_leftover", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/spi_flash_responder.md
Name: spi_flash_responder

Overview:
Synthesizable SPI NOR-flash responder model that answers the XIP read sequence issued by the APB SPI master bridge on the SoC flash port.
- Decodes the READ command (0x03) plus a 24-bit address, then streams bytes from an internal word memory on MISO until SS deasserts.
- Sits on the spi_sck/spi_ss[0]/spi_mosi/spi_miso pins in simulation and on FPGA.
- A backdoor port preloads the image.

Parameters:
- MEM_WORDS, 4096, 32-bit words of storage (16 KiB); power of two.
- CMD_READ, 8'h03, opcode accepted as a read.
- ADDR_W, 24, address bits received after the opcode.

Ports:
- clock  in  1  system clock; all logic sampled here.
- reset  in  1  reset, asynchronous, active-high.
- spi_sck  in  1  serial clock from master, CPOL=0.
- spi_ss_n  in  1  chip select, active-low.
- spi_mosi  in  1  master-out data.
- spi_miso  out  1  slave-out data.
- bd_we  in  1  backdoor write strobe.
- bd_addr  in  $clog2(MEM_WORDS)  backdoor word address.
- bd_wdata  in  32  backdoor write data; byte 0 = bits [7:0].
- busy  out  1  high while a frame is active (synced SS low).
- cmd_err  out  1  one-cycle pulse when a non-read opcode completes.

Behaviour:
- Reset values: spi_miso=0, busy=0, cmd_err=0, state=IDLE, shift/bit counters=0.
- Synchronization:
  - sck, ss_n and mosi each pass through an identical 2-flop synchronizer, then a third edge-detect flop.
  - Skew between the three signals is therefore zero.
  - Requirement: SCK high and low phases each ≥2 clock cycles; master divider=1 gives exactly 2.
- Protocol: SPI mode 0, MSB first.
  - MOSI is sampled on the synced sck rising edge.
  - MISO is updated on the synced sck falling edge.
- States: IDLE, CMD, ADDR, DATA, IGNORE.
  - IDLE: on synced ss_n falling edge -> CMD; bit counter=0; busy=1.
  - CMD: shift 8 bits. After the 8th rising edge:
    - opcode==CMD_READ -> ADDR.
    - otherwise -> IGNORE, and pulse cmd_err the same cycle.
  - ADDR: shift 24 bits. After the 24th rising edge:
    - byte pointer = address mod (4*MEM_WORDS).
    - issue memory read of word pointer>>2.
    - go to DATA.
  - DATA:
    - The byte selected by pointer[1:0] loads into the 8-bit out shifter before the next falling edge; read latency is 1 clock and fits within the ≥2-clock low phase.
    - Each falling edge drives shifter[7] onto spi_miso, then shifts left.
    - After 8 bits: pointer increments; the next word read was prefetched when pointer[1:0]==3 at bit 4.
    - Pointer wraps from 4*MEM_WORDS-1 to 0.
  - IGNORE: spi_miso held 0; MOSI discarded.
- Any state, synced ss_n rising edge: next cycle -> IDLE, busy=0, spi_miso=0, partial bytes discarded.
  - Applies mid-command and mid-address; no read is issued.
- The first data bit appears on the falling edge that follows the 32nd rising edge.
  - A master shifting 64 bits therefore sees 32 bits of data in RX bits [31:0], first byte in bits [31:24].
- Memory: 1R1W synchronous.
  - Backdoor write and a frame read of the same word in the same cycle: the read returns old data; the write always succeeds.
- Reset asserted mid-frame: immediate return to reset values; memory contents preserved, with no reset on the array.

Optional Feature:
SPI_FLASH_FAST_READ_EN:
- Defined: opcode 8'h0B is also accepted. It takes ADDR, then a DUMMY state of 8 sck cycles (MOSI ignored, MISO=0), then DATA.
- Undefined: 0x0B is treated as an unknown opcode -> IGNORE with a cmd_err pulse.

Decomposition:
- Package spi_flash_pkg:
  - state enum (IDLE/CMD/ADDR/DUMMY/DATA/IGNORE).
  - opcode constants CMD_READ=8'h03, CMD_FAST_READ=8'h0B.
  - DUMMY_CYCLES=8.
- Sub-module spi_flash_mem: parameterized MEM_WORDS×32 synchronous RAM, one read port and one write port, registered read.
- Synchronizers and the frame FSM stay in spi_flash_responder.

Test Plan:
- Preload word 0 = 32'h04030201; master sends 0x03,0x000000 then 32 clocks -> MISO bytes 0x01,0x02,0x03,0x04; RX = 32'h01020304; busy falls 3 clocks after SS high.
- Address 0x000002 with word0=32'h44332211, word1=32'h88776655, 32 data clocks -> bytes 0x33,0x44,0x55,0x66 (word-crossing prefetch).
- Address 0x003FFF (last byte, MEM_WORDS=4096) with last byte 0xAA, word0 byte0 0x11 -> bytes 0xAA,0x11 (wrap-around).
- Opcode 0x9F -> cmd_err one-cycle pulse after bit 8; MISO stays 0 for the remaining 56 clocks; the next 0x03 frame reads correctly.
- SS deasserted after 20 bits (mid-address) -> IDLE, MISO=0, no read issued; the following full read returns correct data.
- Reset pulsed during the DATA phase -> spi_miso=0, busy=0 immediately; memory unchanged on the next read. With SPI_FLASH_FAST_READ_EN: 0x0B + addr + 8 dummy clocks -> same data as the 0x03 case.
